// File: rtl/riscv_pkg.sv
// Shared RV32 definitions used by the M-extension execute unit.
package riscv_pkg;

   localparam logic [6:0] OPCODE_OP     = 7'b0110011;
   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } md_state_e;

   function automatic logic f3_is_div(input logic [2:0] f3);
      return f3[2];
   endfunction

   function automatic logic f3_is_rem(input logic [2:0] f3);
      return f3[2] & f3[1];
   endfunction

   // rs1 is a signed operand for MULH, MULHSU, DIV, REM
   function automatic logic f3_rs1_signed(input logic [2:0] f3);
      return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

   // rs2 is a signed operand for MULH, DIV, REM
   function automatic logic f3_rs2_signed(input logic [2:0] f3);
      return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negation: absolute value of a signed operand
// on accept, and sign restoration of the unsigned result on fixup.
module muldiv_sign_fix #(
   parameter int W = 32
) (
   input  logic [W-1:0] val_i,
   input  logic         neg_i,
   output logic [W-1:0] val_o
);

   assign val_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit. Operates on magnitudes, one
// shift-add (multiply) or restoring (divide) step per cycle, then restores
// the sign. Divide-by-zero and signed overflow bypass the iteration.
module ex_muldiv_unit
   import riscv_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            valid_i,
   input  logic            flush_i,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] rs1_data_i,
   input  logic [XLEN-1:0] rs2_data_i,
   input  logic [4:0]      rd_addr_i,
   output logic            stall_o,
   output logic            result_valid_o,
   output logic [XLEN-1:0] result_o,
   output logic [4:0]      rd_addr_o
);

   md_state_e        state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       f3_q;
   logic [4:0]       rd_q;
   logic             neg_q;
   // opd_q: multiplicand (mul) or divisor (div); hi_q/lo_q: accumulator
   // halves, or partial remainder / dividend-shifting-into-quotient
   logic [XLEN-1:0]  opd_q, hi_q, lo_q;

   // ---------------- accept path ----------------
   logic            rs1_neg, rs2_neg;
   logic [XLEN-1:0] rs1_abs, rs2_abs;
   logic            div_zero, div_ovf, special;
   logic [XLEN-1:0] special_res;
   logic            accept, last_iter;

   assign rs1_neg = f3_rs1_signed(funct3_i) & rs1_data_i[XLEN-1];
   assign rs2_neg = f3_rs2_signed(funct3_i) & rs2_data_i[XLEN-1];

   muldiv_sign_fix #(.W(XLEN)) u_abs_rs1 (.val_i(rs1_data_i), .neg_i(rs1_neg), .val_o(rs1_abs));
   muldiv_sign_fix #(.W(XLEN)) u_abs_rs2 (.val_i(rs2_data_i), .neg_i(rs2_neg), .val_o(rs2_abs));

   assign div_zero = f3_is_div(funct3_i) & (rs2_data_i == '0);
   // DIV/REM only (funct3[0]==0): most-negative / -1
   assign div_ovf  = f3_is_div(funct3_i) & ~funct3_i[0]
                   & (rs1_data_i == {1'b1, {(XLEN-1){1'b0}}}) & (rs2_data_i == '1);
   assign special  = div_zero | div_ovf;

   // architectural results for the cases that skip iteration
   always_comb begin
      special_res = '0;
      if (div_zero)
         special_res = f3_is_rem(funct3_i) ? rs1_data_i : '1;
      else if (div_ovf)
         special_res = f3_is_rem(funct3_i) ? '0 : rs1_data_i;
   end

   assign accept    = (state == IDLE) & valid_i & ~flush_i;
   assign last_iter = (state == CALC) & (cnt == CNT_W'(XLEN - 1));

   // ---------------- iteration step ----------------
   logic [XLEN:0]     mul_sum, div_sh, div_diff;
   logic [XLEN-1:0]   hi_n, lo_n;
   logic [2*XLEN-1:0] fix_in, fix_out;
   logic [XLEN-1:0]   fix_res;

   assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
   assign div_sh   = {hi_q, lo_q[XLEN-1]};
   assign div_diff = div_sh - {1'b0, opd_q};

   // next accumulator: shift-add for multiply, restore-or-keep for divide
   always_comb begin
      hi_n = mul_sum[XLEN:1];
      lo_n = {mul_sum[0], lo_q[XLEN-1:1]};
      if (f3_is_div(f3_q)) begin
         hi_n = div_diff[XLEN] ? div_sh[XLEN-1:0] : div_diff[XLEN-1:0];
         lo_n = {lo_q[XLEN-2:0], ~div_diff[XLEN]};
      end
   end

   // sign fixup applies to the final step's output so the result is ready
   // on the CALC->DONE edge
   assign fix_in = f3_is_div(f3_q) ? {{XLEN{1'b0}}, (f3_is_rem(f3_q) ? hi_n : lo_n)}
                                   : {hi_n, lo_n};

   muldiv_sign_fix #(.W(2*XLEN)) u_fix (.val_i(fix_in), .neg_i(neg_q), .val_o(fix_out));

   assign fix_res = ((f3_q == F3_MUL) || f3_is_div(f3_q)) ? fix_out[XLEN-1:0]
                                                          : fix_out[2*XLEN-1:XLEN];

   // ---------------- control ----------------
   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // next state and handshake outputs; flush overrides accept and completion
   always_comb begin
      state_nxt      = state;
      stall_o        = valid_i & ~flush_i & ~rst & (state != DONE);
      result_valid_o = (state == DONE) & ~flush_i & ~rst;
      case (state)
         IDLE:    if (accept)    state_nxt = special ? DONE : CALC;
         CALC:    if (last_iter) state_nxt = DONE;
         DONE:                   state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
      if (flush_i) state_nxt = IDLE;
   end

   // operand latch, iteration datapath and result register
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         f3_q      <= '0;
         rd_q      <= '0;
         neg_q     <= 1'b0;
         opd_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         result_o  <= '0;
         rd_addr_o <= '0;
      end else if (flush_i) begin
         cnt <= '0;
      end else if (accept) begin
         cnt   <= '0;
         f3_q  <= funct3_i;
         rd_q  <= rd_addr_i;
         neg_q <= f3_is_rem(funct3_i) ? rs1_neg : (rs1_neg ^ rs2_neg);
         hi_q  <= '0;
         opd_q <= f3_is_div(funct3_i) ? rs2_abs : rs1_abs;
         lo_q  <= f3_is_div(funct3_i) ? rs1_abs : rs2_abs;
         if (special) begin
            result_o  <= special_res;
            rd_addr_o <= rd_addr_i;
         end
      end else if (state == CALC) begin
         hi_q <= hi_n;
         lo_q <= lo_n;
         cnt  <= cnt + CNT_W'(1);
         if (last_iter) begin
            cnt       <= '0;
            result_o  <= fix_res;
            rd_addr_o <= rd_q;
         end
      end
   end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit with an arithmetic reference model and a
// per-cycle scoreboard compare.
module tb_ex_muldiv_unit;
   import riscv_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1, valid_i = 1'b0, flush_i = 1'b0;
   logic [2:0]  funct3_i = '0;
   logic [31:0] rs1_data_i = '0, rs2_data_i = '0;
   logic [4:0]  rd_addr_i = '0;
   logic        stall_o, result_valid_o;
   logic [31:0] result_o;
   logic [4:0]  rd_addr_o;

   ex_muldiv_unit #(.XLEN(32), .CNT_W(5)) dut (
      .clk(clk), .rst(rst), .valid_i(valid_i), .flush_i(flush_i),
      .funct3_i(funct3_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
      .rd_addr_i(rd_addr_i), .stall_o(stall_o), .result_valid_o(result_valid_o),
      .result_o(result_o), .rd_addr_o(rd_addr_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          due;
      logic [31:0] res;
      logic [4:0]  rd;
   } exp_t;
   exp_t q[$];

   int n_cmp = 0, n_bad = 0;
   bit chk_en = 1'b0;
   int last_pulse = -1;
   int stall_cnt = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // RV32M semantics from plain 64-bit arithmetic
   function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb, ua, ub, p;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'b0, a};
      ub = {32'b0, b};
      p  = '0;
      case (f3)
         F3_MUL:    begin p = ua * ub; return p[31:0];  end
         F3_MULH:   begin p = sa * sb; return p[63:32]; end
         F3_MULHSU: begin p = sa * ub; return p[63:32]; end
         F3_MULHU:  begin p = ua * ub; return p[63:32]; end
         F3_DIV:    begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            p = sa / sb; return p[31:0];
         end
         F3_DIVU:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         F3_REM:    begin
            if (b == 32'd0) return a;
            p = sa % sb; return p[31:0];
         end
         default:   return (b == 32'd0) ? a : a % b;
      endcase
   endfunction

   // divide by zero and most-negative / -1 finish the cycle after accept
   function automatic int lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      if (f3[2] && b == 32'd0) return 1;
      if ((f3 == F3_DIV || f3 == F3_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
   endfunction

   // per-cycle compare of the handshake and, on pulses, the payload
   always @(negedge clk) begin : cmp
      logic ev, st;
      if (chk_en) begin
         ev = (q.size() > 0) && (q[0].due == cyc) && !flush_i;
         st = valid_i && !flush_i && !rst && !ev;
         check("result_valid", 32'(result_valid_o), 32'(ev));
         check("stall", 32'(stall_o), 32'(st));
         if (stall_o) stall_cnt++;
         if (ev) begin
            check("result", result_o, q[0].res);
            check("rd_addr", 32'(rd_addr_o), 32'(q[0].rd));
            last_pulse = cyc;
         end
         if (q.size() > 0 && q[0].due <= cyc) void'(q.pop_front());
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output int due);
      exp_t e;
      valid_i    = 1'b1;
      funct3_i   = f3;
      rs1_data_i = a;
      rs2_data_i = b;
      rd_addr_i  = rd;
      due   = cyc + lat(f3, a, b);
      e.due = due;
      e.res = model(f3, a, b);
      e.rd  = rd;
      q.push_back(e);
   endtask

   // present an op, hold it through its DONE cycle, then release
   task automatic run_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic [31:0] pin);
      int due;
      check({"model ", nm}, model(f3, a, b), pin);
      start(f3, a, b, rd, due);
      while (cyc <= due) tick();
      valid_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int due, p1;
      // reset; valid_i held high to show stall stays low under reset
      rst = 1'b1; valid_i = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      check("rst result_o", result_o, 32'd0);
      check("rst rd_addr_o", 32'(rd_addr_o), 32'd0);
      check("rst result_valid", 32'(result_valid_o), 32'd0);
      check("rst stall", 32'(stall_o), 32'd0);
      tick();
      rst = 1'b0; valid_i = 1'b0; chk_en = 1'b1;
      tick();

      // MUL with 33-cycle stall window
      stall_cnt = 0;
      run_op("mul", F3_MUL, 32'd7, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB);
      check("mul stall cycles", 32'(stall_cnt), 32'd33);

      run_op("mulh",   F3_MULH,   32'h8000_0000, 32'h8000_0000, 5'd2,  32'h4000_0000);
      run_op("mulhu",  F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE);
      run_op("mulhsu", F3_MULHSU, 32'hFFFF_FFFF, 32'd2,         5'd4,  32'hFFFF_FFFF);
      run_op("div",    F3_DIV,    32'hFFFF_FFF9, 32'd2,         5'd7,  32'hFFFF_FFFD);
      run_op("rem",    F3_REM,    32'hFFFF_FFF9, 32'd2,         5'd8,  32'hFFFF_FFFF);
      run_op("divu",   F3_DIVU,   32'd100,       32'd7,         5'd9,  32'd14);
      run_op("remu",   F3_REMU,   32'd100,       32'd7,         5'd10, 32'd2);
      run_op("div0",   F3_DIV,    32'd5,         32'd0,         5'd11, 32'hFFFF_FFFF);
      run_op("remu0",  F3_REMU,   32'd5,         32'd0,         5'd12, 32'd5);
      run_op("divovf", F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000);
      run_op("removf", F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0);
      run_op("mul x0", F3_MUL,    32'h0001_0000, 32'h0001_0003, 5'd0,  32'h0003_0000);

      // flush at CALC iteration 10, then a normal op straight away
      start(F3_DIVU, 32'd100, 32'd7, 5'd15, due);
      repeat (11) tick();
      flush_i = 1'b1;
      q.delete();
      tick();
      flush_i = 1'b0;
      run_op("after flush", F3_REM, 32'hFFFF_FFF9, 32'd2, 5'd16, 32'hFFFF_FFFF);

      // flush in the DONE cycle suppresses the pulse
      start(F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd17, due);
      while (cyc < due) tick();
      flush_i = 1'b1;
      q.delete();
      tick();
      flush_i = 1'b0; valid_i = 1'b0;
      tick();

      // back-to-back: second accepted the cycle after DONE
      run_op("b2b mul", F3_MUL, 32'd6, 32'd7, 5'd5, 32'd42);
      p1 = last_pulse;
      run_op("b2b divu", F3_DIVU, 32'd100, 32'd7, 5'd6, 32'd14);
      check("b2b gap", 32'(last_pulse - p1), 32'd34);

      // reset mid-CALC
      start(F3_MUL, 32'd3, 32'd5, 5'd9, due);
      repeat (5) tick();
      rst = 1'b1;
      q.delete();
      tick();
      rst = 1'b0; valid_i = 1'b0;
      @(negedge clk);
      check("midrst result_o", result_o, 32'd0);
      check("midrst rd_addr_o", 32'(rd_addr_o), 32'd0);
      check("midrst result_valid", 32'(result_valid_o), 32'd0);
      check("midrst stall", 32'(stall_o), 32'd0);
      repeat (3) tick();

      // unit still works after a mid-op reset
      run_op("after rst", F3_DIV, 32'd100, 32'hFFFF_FFF9, 5'd20, 32'hFFFF_FFF2);
      repeat (3) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
